// File: rtl/fifo_stream_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_stream_ctrl_pkg : shared fifo geometry and helper types
// Revision: 1.0
// ----------------------------------------------------------------------------
package fifo_stream_ctrl_pkg;

  localparam int FIFO_ADDR_WIDTH  = 9;
  localparam int FIFO_DATA_WIDTH  = 128;
  localparam int FIFO_DEPTH       = 512;
  localparam int FIFO_AFULL_LEVEL = 480;

  // Side that won the most recent grant, used by the round-robin arbiter.
  typedef enum logic {
    SIDE_WRITE = 1'b0,
    SIDE_READ  = 1'b1
  } side_e;

  // Level counts fifo words plus the two buffered words, so one extra bit.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_ctrl_out_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_out_buf : 2-entry registered output buffer, entry 0 is the head
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_out_buf
  import fifo_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
    end else if (push && !pop) begin
      r_count <= r_count + 2'd1;
    end else if (pop && !push) begin
      r_count <= r_count - 2'd1;
    end
  end

  // On a simultaneous push/pop with one entry held, the new word becomes head.
  always_ff @(posedge clk) begin
    if (pop) begin
      r_entry0 <= (push && r_count == 2'd1) ? push_data : r_entry1;
      if (push) begin
        r_entry1 <= push_data;
      end
    end else if (push) begin
      if (r_count == 2'd0) begin
        r_entry0 <= push_data;
      end else begin
        r_entry1 <= push_data;
      end
    end
  end

  assign head_data = r_entry0;
  assign count     = r_count;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= 2'd2);
      assert (!(pop && r_count == 2'd0));
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_stream_ctrl : valid/ready stream front-end for the single-port BRAM fifo
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_stream_ctrl
  import fifo_stream_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH       = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH       = FIFO_DATA_WIDTH,
  parameter int DEPTH            = FIFO_DEPTH,
  parameter int ALLOW_CONCURRENT = 1,
  parameter int AFULL_LEVEL      = FIFO_AFULL_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_write_e,
  output logic                  fifo_read_e,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  fifo_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  afull
);

  localparam int c_level_width = level_width(ADDR_WIDTH);
  localparam logic [c_level_width-1:0] c_afull_level = c_level_width'(AFULL_LEVEL);
  localparam logic [c_level_width-1:0] c_level_max   = c_level_width'(DEPTH + 2);

  logic                     w_wr_req;
  logic                     w_rd_req;
  logic                     w_grant_w;
  logic                     w_grant_r;
  logic                     r_rd_inflight;
  logic [1:0]               w_buf_count;
  logic [1:0]               w_occupied;
  logic                     w_in_beat;
  logic                     w_out_beat;
  logic [c_level_width-1:0] r_level;
  logic [c_level_width-1:0] w_level_nxt;
  logic                     r_afull;

  // A read is only issued if its word is guaranteed a buffer slot on return.
  assign w_occupied = w_buf_count + {1'b0, r_rd_inflight};
  assign w_wr_req   = !reset && s_tvalid && !fifo_full && fifo_ready;
  assign w_rd_req   = !reset && !fifo_empty && fifo_ready && (w_occupied < 2'd2);

  generate
    if (ALLOW_CONCURRENT != 0) begin : g_concurrent
      assign w_grant_w = w_wr_req;
      assign w_grant_r = w_rd_req;
    end else begin : g_round_robin
      side_e r_rr_last;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rr_last <= SIDE_WRITE;
        end else if (w_grant_w) begin
          r_rr_last <= SIDE_WRITE;
        end else if (w_grant_r) begin
          r_rr_last <= SIDE_READ;
        end
      end

      always_comb begin
        w_grant_w = w_wr_req;
        w_grant_r = w_rd_req;
        if (w_wr_req && w_rd_req) begin
          w_grant_w = (r_rr_last == SIDE_READ);
          w_grant_r = (r_rr_last == SIDE_WRITE);
        end
      end
    end
  endgenerate

  assign fifo_write_e = w_grant_w;
  assign fifo_read_e  = w_grant_r;
  assign fifo_wdata   = s_tdata;
  assign s_tready     = w_grant_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_grant_r;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (r_rd_inflight),
    .push_data(fifo_rdata),
    .pop      (w_out_beat),
    .head_data(m_tdata),
    .count    (w_buf_count)
  );

  assign m_tvalid   = (w_buf_count != 2'd0);
  assign w_in_beat  = s_tvalid && s_tready;
  assign w_out_beat = m_tvalid && m_tready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_in_beat && !w_out_beat) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_out_beat && !w_in_beat) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_afull <= (w_level_nxt >= c_afull_level);
    end
  end

  assign level = r_level;
  assign afull = r_afull;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_out_beat && !w_in_beat && r_level == '0));
      assert (r_level <= c_level_max);
      assert (!((fifo_write_e || fifo_read_e) && !fifo_ready));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_stream_ctrl : both arbitration modes against a queue-based model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fifo_stream_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int AFL   = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_tvalid_g;
  logic        m_tready_g;
  int          wr_limit;
  logic [31:0] seq_base;
  bit          rand_data;
  bit          busy_en;
  int          checks = 0;
  int          errors = 0;

  logic [DW-1:0] s_tdata    [2];
  logic [DW-1:0] m_tdata    [2];
  logic [DW-1:0] fifo_wdata [2];
  logic [DW-1:0] fifo_rdata [2];
  logic          s_tvalid   [2];
  logic          s_tready   [2];
  logic          m_tvalid   [2];
  logic          m_tready   [2];
  logic          fifo_write_e [2];
  logic          fifo_read_e  [2];
  logic          fifo_full  [2];
  logic          fifo_empty [2];
  logic          fifo_ready [2];
  logic          afull      [2];
  logic [AW:0]   level      [2];

  task automatic check(input string name, input int idx,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit CONC = (g == 0);

    fifo_stream_ctrl #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .DEPTH           (DEPTH),
      .ALLOW_CONCURRENT(CONC ? 1 : 0),
      .AFULL_LEVEL     (AFL)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .s_tdata     (s_tdata[g]),
      .s_tvalid    (s_tvalid[g]),
      .s_tready    (s_tready[g]),
      .m_tdata     (m_tdata[g]),
      .m_tvalid    (m_tvalid[g]),
      .m_tready    (m_tready[g]),
      .fifo_wdata  (fifo_wdata[g]),
      .fifo_write_e(fifo_write_e[g]),
      .fifo_read_e (fifo_read_e[g]),
      .fifo_rdata  (fifo_rdata[g]),
      .fifo_full   (fifo_full[g]),
      .fifo_empty  (fifo_empty[g]),
      .fifo_ready  (fifo_ready[g]),
      .level       (level[g]),
      .afull       (afull[g])
    );

    logic [DW-1:0] envq [$];   // contents of the BRAM fifo
    logic [DW-1:0] sbq  [$];   // accepted words not yet delivered
    int            n_path;     // words read from the fifo, not yet delivered
    bit            inflight;
    bit            rr_last_r;  // 1: last grant was a read
    bit            e_w, e_r, e_pop;
    bit            a_w, a_r, a_acc, a_pop;
    logic [DW-1:0] lat_sdata, lat_wdata, lat_mdata;
    int            n_acc, n_out, n_reads;
    logic [31:0]   first_out [4];
    logic [31:0]   seq;
    logic [95:0]   upper;

    assign s_tvalid[g] = s_tvalid_g && (n_acc < wr_limit);
    assign m_tready[g] = m_tready_g;
    assign s_tdata[g]  = {upper, seq};

    always @(negedge clk) begin
      bit wr_req, rd_req, exp_mv;
      int nbuf;
      nbuf   = n_path - (inflight ? 1 : 0);
      wr_req = !reset && s_tvalid[g] && !fifo_full[g] && fifo_ready[g];
      rd_req = !reset && !fifo_empty[g] && fifo_ready[g] && (n_path < 2);
      e_w = wr_req;
      e_r = rd_req;
      if (!CONC && wr_req && rd_req) begin
        e_w = rr_last_r;
        e_r = !rr_last_r;
      end
      exp_mv = (nbuf > 0);
      e_pop  = exp_mv && m_tready[g];

      check("s_tready", g, s_tready[g], e_w);
      check("fifo_write_e", g, fifo_write_e[g], e_w);
      check("fifo_read_e", g, fifo_read_e[g], e_r);
      check("m_tvalid", g, m_tvalid[g], exp_mv);
      check("level", g, DW'(level[g]), DW'(sbq.size()));
      check("afull", g, afull[g], sbq.size() >= AFL);
      if (exp_mv && sbq.size() > 0) check("m_tdata", g, m_tdata[g], sbq[0]);
      if (e_w) check("fifo_wdata", g, fifo_wdata[g], s_tdata[g]);
      if (!CONC) check("single_cmd", g, fifo_write_e[g] & fifo_read_e[g], 1'b0);

      lat_sdata = s_tdata[g];
      lat_wdata = fifo_wdata[g];
      lat_mdata = m_tdata[g];
      a_w   = fifo_write_e[g];
      a_r   = fifo_read_e[g];
      a_acc = s_tvalid[g] && s_tready[g];
      a_pop = m_tvalid[g] && m_tready[g];
    end

    always @(posedge clk) begin
      logic [DW-1:0] tmp;
      if (reset) begin
        envq.delete();
        sbq.delete();
        n_path    = 0;
        inflight  = 1'b0;
        rr_last_r = 1'b0;
        fifo_ready[g] <= 1'b1;
        fifo_full[g]  <= 1'b0;
        fifo_empty[g] <= 1'b1;
        fifo_rdata[g] <= '0;
        n_acc   <= 0;
        n_out   <= 0;
        n_reads <= 0;
        seq     <= seq_base;
        upper   <= '0;
      end else begin
        if (e_pop) begin
          if (sbq.size() > 0) void'(sbq.pop_front());
          n_path--;
        end
        if (e_w) sbq.push_back(lat_sdata);
        if (e_r) n_path++;
        inflight = e_r;
        if (e_w || e_r) rr_last_r = e_r;

        if (a_r) begin
          check("read_when_empty", g, envq.size() == 0, 1'b0);
          if (envq.size() > 0) begin
            tmp = envq.pop_front();
            fifo_rdata[g] <= tmp;
          end
          n_reads <= n_reads + 1;
        end
        if (a_w) begin
          check("write_when_full", g, envq.size() >= DEPTH, 1'b0);
          if (envq.size() < DEPTH) envq.push_back(lat_wdata);
        end
        fifo_full[g]  <= (envq.size() >= DEPTH);
        fifo_empty[g] <= (envq.size() == 0);
        fifo_ready[g] <= !(a_w && a_r) && !(busy_en && $urandom_range(0, 7) == 0);

        if (a_acc) begin
          n_acc <= n_acc + 1;
          seq   <= seq + 1;
          upper <= rand_data ? {$urandom(), $urandom(), $urandom()} : 96'd0;
        end
        if (a_pop) begin
          if (n_out < 4) first_out[n_out] <= lat_mdata[31:0];
          n_out <= n_out + 1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  a0, a1;
    bit  found;
    reset      = 1'b1;
    s_tvalid_g = 1'b1;
    m_tready_g = 1'b0;
    wr_limit   = 4;
    seq_base   = 32'd1;
    rand_data  = 1'b0;
    busy_en    = 1'b0;
    step(3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_s_tready", i, s_tready[i], 1'b0);
      check("rst_write_e", i, fifo_write_e[i], 1'b0);
      check("rst_m_tvalid", i, m_tvalid[i], 1'b0);
      check("rst_level", i, DW'(level[i]), '0);
      check("rst_afull", i, afull[i], 1'b0);
    end

    // four words with the output stalled
    @(posedge clk); #1 reset = 1'b0;
    step(20);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("stall_level", i, DW'(level[i]), DW'(4));
      check("stall_m_tvalid", i, m_tvalid[i], 1'b1);
      check("stall_m_tdata", i, m_tdata[i], DW'(32'h1));
    end
    check("stall_reads", 0, DW'(g_inst[0].n_reads), DW'(2));
    check("stall_reads", 1, DW'(g_inst[1].n_reads), DW'(2));

    // drain in order
    @(posedge clk); #1 m_tready_g = 1'b1;
    step(10);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("drain_level", i, DW'(level[i]), '0);
      check("drain_m_tvalid", i, m_tvalid[i], 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      check("order", 0, DW'(g_inst[0].first_out[k]), DW'(k + 1));
      check("order", 1, DW'(g_inst[1].first_out[k]), DW'(k + 1));
    end

    // both streams saturated: one input beat every two cycles
    @(posedge clk); #1;
    rand_data = 1'b1;
    wr_limit  = 1 << 30;
    step(20);
    a0 = g_inst[0].n_acc;
    a1 = g_inst[1].n_acc;
    step(100);
    check("throughput", 0, (g_inst[0].n_acc - a0 >= 49) && (g_inst[0].n_acc - a0 <= 51), 1'b1);
    check("throughput", 1, (g_inst[1].n_acc - a1 >= 49) && (g_inst[1].n_acc - a1 <= 51), 1'b1);

    // random traffic with random fifo busy cycles
    busy_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      s_tvalid_g = ($urandom_range(0, 1) == 1);
      m_tready_g = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // drain, then fill to capacity
    busy_en    = 1'b0;
    s_tvalid_g = 1'b0;
    m_tready_g = 1'b1;
    step(40);
    s_tvalid_g = 1'b1;
    m_tready_g = 1'b0;
    step(600);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("full_level", i, DW'(level[i]), DW'(DEPTH + 2));
      check("full_afull", i, afull[i], 1'b1);
      check("full_s_tready", i, s_tready[i], 1'b0);
    end

    // reset with a read in flight
    @(posedge clk); #1;
    s_tvalid_g = 1'b0;
    m_tready_g = 1'b1;
    seq_base   = 32'hA5;
    found      = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (fifo_read_e[0]) found = 1'b1;
    end
    check("read_seen", 0, found, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midrst_m_tvalid", i, m_tvalid[i], 1'b0);
      check("midrst_level", i, DW'(level[i]), '0);
    end
    @(posedge clk); #1;
    reset      = 1'b0;
    s_tvalid_g = 1'b1;
    step(20);
    check("post_rst_first", 0, DW'(g_inst[0].first_out[0]), DW'(32'hA5));
    check("post_rst_first", 1, DW'(g_inst[1].first_out[0]), DW'(32'hA5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
